// File: rtl/gshare_spec_pkg.sv
// Shared types and constants for the gshare branch predictor.
//   bp_state_t : predictor FSM state (PHT init sweep, then normal operation)
//   br_opcode  : RV32I conditional-branch opcode used to filter commits
//   weak_nt    : weakly-not-taken counter value for a given counter width
package gshare_spec_pkg;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    localparam logic [6:0] br_opcode = 7'b1100011;

    function automatic int unsigned weak_nt(input int unsigned counter_bits);
        return (32'd1 << (counter_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/gshare_spec_pht.sv
// Pattern history table: NUM_ENT saturating counters, one combinational read port
// and one write port. The write port either loads the weakly-not-taken value
// (init sweep) or applies a saturating increment/decrement to the addressed entry.
// The array has no reset; the top-level init FSM sweeps it instead.
//   clk        : clock
//   rd_idx_i   : fetch read index
//   rd_cnt_o   : counter at rd_idx_i (pre-write value in a collision cycle)
//   wr_en_i    : write enable
//   wr_init_i  : 1 = load weakly-not-taken, 0 = train with wr_taken_i
//   wr_idx_i   : write index
//   wr_taken_i : training outcome (1 = increment, 0 = decrement)
module gshare_spec_pht
    import gshare_spec_pkg::*;
#(
    parameter int unsigned PHT_DEPTH    = 10,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic                    clk,
    input  logic [PHT_DEPTH-1:0]    rd_idx_i,
    output logic [COUNTER_BITS-1:0] rd_cnt_o,
    input  logic                    wr_en_i,
    input  logic                    wr_init_i,
    input  logic [PHT_DEPTH-1:0]    wr_idx_i,
    input  logic                    wr_taken_i
);

    localparam int unsigned NUM_ENT = 2 ** PHT_DEPTH;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_MIN  = '0;
    localparam logic [COUNTER_BITS-1:0] CNT_WEAK = COUNTER_BITS'(weak_nt(COUNTER_BITS));

    logic [COUNTER_BITS-1:0] pht_q [NUM_ENT];
    logic [COUNTER_BITS-1:0] wr_old;
    logic [COUNTER_BITS-1:0] wr_data;

    assign rd_cnt_o = pht_q[rd_idx_i];

    always_comb begin
        wr_old  = pht_q[wr_idx_i];
        wr_data = wr_old;
        if (wr_init_i) begin
            wr_data = CNT_WEAK;
        end else if (wr_taken_i) begin
            if (wr_old != CNT_MAX) wr_data = wr_old + COUNTER_BITS'(1);
        end else begin
            if (wr_old != CNT_MIN) wr_data = wr_old - COUNTER_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) pht_q[wr_idx_i] <= wr_data;
    end

endmodule

// File: rtl/gshare_spec.sv
// gshare conditional-branch predictor with a speculative global history register.
// Fetch indexes the PHT with spec_ghr ^ pc and returns the prediction plus the
// history snapshot used; commit trains the PHT at the snapshot index and, on a
// mispredict, rebuilds spec_ghr from the snapshot and the resolved outcome.
// After reset the PHT is swept to weakly-not-taken, one entry per cycle.
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_*         : fetch slot (valid, is-branch, pc)
//   pred_take       : predicted direction (combinational)
//   pred_ghr        : history snapshot used for this prediction
//   pred_ready      : predictor initialised; fetch stalls while low
//   commit_*        : ROB pop (valid, opcode, pc, ghr snapshot, outcome, mispredict)
module gshare_spec
    import gshare_spec_pkg::*;
#(
    parameter int unsigned GHR_DEPTH    = 30,
    parameter int unsigned PHT_DEPTH    = 10,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic                 fetch_is_br,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_take,
    output logic [GHR_DEPTH-1:0] pred_ghr,
    output logic                 pred_ready,
    input  logic                 commit_valid,
    input  logic [6:0]           commit_opcode,
    input  logic [31:0]          commit_pc,
    input  logic [GHR_DEPTH-1:0] commit_ghr,
    input  logic                 commit_taken,
    input  logic                 commit_mispred
);

    localparam logic [PHT_DEPTH-1:0] LAST_IDX = '1;

    bp_state_t              state_q, state_d;
    logic [PHT_DEPTH-1:0]   sweep_ptr_q, sweep_ptr_d;
    logic [GHR_DEPTH-1:0]   spec_ghr_q, spec_ghr_d;

    logic [PHT_DEPTH-1:0]    fetch_idx;
    logic [PHT_DEPTH-1:0]    commit_idx;
    logic [COUNTER_BITS-1:0] rd_cnt;
    logic                    in_run;
    logic                    do_train;
    logic                    pht_wr_en;
    logic                    pht_wr_init;
    logic [PHT_DEPTH-1:0]    pht_wr_idx;

    assign fetch_idx  = spec_ghr_q[PHT_DEPTH-1:0] ^ fetch_pc[PHT_DEPTH+1:2];
    assign commit_idx = commit_ghr[PHT_DEPTH-1:0] ^ commit_pc[PHT_DEPTH+1:2];

    assign in_run   = (state_q == BP_RUN);
    assign do_train = in_run & commit_valid & (commit_opcode == br_opcode);

    // Outputs are forced quiet during the sweep since unswept entries are undefined.
    assign pred_ready = in_run;
    assign pred_take  = in_run & rd_cnt[COUNTER_BITS-1];
    assign pred_ghr   = in_run ? spec_ghr_q : '0;

    // Single write port: the sweep owns it in INIT, commit training owns it in RUN.
    assign pht_wr_en   = ~in_run | do_train;
    assign pht_wr_init = ~in_run;
    assign pht_wr_idx  = in_run ? commit_idx : sweep_ptr_q;

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        spec_ghr_d  = spec_ghr_q;
        unique case (state_q)
            BP_INIT: begin
                sweep_ptr_d = sweep_ptr_q + PHT_DEPTH'(1);
                if (sweep_ptr_q == LAST_IDX) state_d = BP_RUN;
            end
            BP_RUN: begin
                // Repair takes priority over the same-cycle speculative shift.
                if (do_train && commit_mispred) begin
                    spec_ghr_d = {commit_ghr[GHR_DEPTH-2:0], commit_taken};
                end else if (fetch_valid && fetch_is_br) begin
                    spec_ghr_d = {spec_ghr_q[GHR_DEPTH-2:0], pred_take};
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BP_INIT;
            sweep_ptr_q <= '0;
            spec_ghr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            spec_ghr_q  <= spec_ghr_d;
        end
    end

    gshare_spec_pht #(
        .PHT_DEPTH    (PHT_DEPTH),
        .COUNTER_BITS (COUNTER_BITS)
    ) u_pht (
        .clk        (clk),
        .rd_idx_i   (fetch_idx),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (pht_wr_en),
        .wr_init_i  (pht_wr_init),
        .wr_idx_i   (pht_wr_idx),
        .wr_taken_i (commit_taken)
    );

    // Only the index bits of the PCs and history feed the PHT.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc, commit_pc, commit_ghr};

endmodule
